// File: rtl/as_gpio_wb_arbiter.sv
// as_gpio_wb_arbiter
//   Two-master Wishbone arbiter in front of the GPIO register port.
//   Master 0 is the CPU data port and master 1 is the DMA/debug master.
//   Masters are served round-robin, and a grant is held for the whole
//   bus cycle (while the owner keeps cyc high). The slave-side signals
//   connect directly to the GPIO wbd* ports.
//
// Optional feature macro: AS_GPIO_ARB_TIMEOUT_EN
//   When this macro is defined, a granted strobe that waits timeout_cycles
//   cycles without an ack is aborted. The owner gets a one-cycle mXErr_o
//   pulse, and the arbiter holds ABORT until that owner drops cyc.
//   When the macro is undefined, there is no counter, ABORT is unreachable,
//   and both err outputs are tied low.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   m{0,1}Addr_i/Dat_i/We_i/Sel_i/Stb_i/Cyc_i   master requests
//   m{0,1}Dat_o/Ack_o     read data / ack, only to the current owner, else 0
//   m{0,1}Err_o           timeout abort pulse
//   sAddr_o..sCyc_o       muxed request to the GPIO slave
//   sDat_i, sAck_i        GPIO read data and ack
//   gnt_o                 one-hot current owner (bit 0 = master 0)
//   busy_o                any grant or abort active
module as_gpio_wb_arbiter #(
  parameter int unsigned addr_width     = 64,
  parameter int unsigned data_width     = 64,
  parameter int unsigned sel_width      = 8,
  parameter int unsigned timeout_cycles = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [addr_width-1:0] m0Addr_i,
  input  logic [data_width-1:0] m0Dat_i,
  output logic [data_width-1:0] m0Dat_o,
  input  logic                  m0We_i,
  input  logic [sel_width-1:0]  m0Sel_i,
  input  logic                  m0Stb_i,
  input  logic                  m0Cyc_i,
  output logic                  m0Ack_o,
  output logic                  m0Err_o,
  input  logic [addr_width-1:0] m1Addr_i,
  input  logic [data_width-1:0] m1Dat_i,
  output logic [data_width-1:0] m1Dat_o,
  input  logic                  m1We_i,
  input  logic [sel_width-1:0]  m1Sel_i,
  input  logic                  m1Stb_i,
  input  logic                  m1Cyc_i,
  output logic                  m1Ack_o,
  output logic                  m1Err_o,
  output logic [addr_width-1:0] sAddr_o,
  output logic [data_width-1:0] sDat_o,
  output logic                  sWe_o,
  output logic [sel_width-1:0]  sSel_o,
  output logic                  sStb_o,
  output logic                  sCyc_o,
  input  logic [data_width-1:0] sDat_i,
  input  logic                  sAck_i,
  output logic [1:0]            gnt_o,
  output logic                  busy_o
);

  if (timeout_cycles == 0) begin : g_bad_timeout
    $error("as_gpio_wb_arbiter: timeout_cycles must be nonzero");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t state_q, state_d;
  // Last granted master. It resets to 1 so master 0 wins the first contention.
  // While the arbiter is in GNTx or ABORT, this value is also the current or aborted owner.
  logic   last_q;
  logic   owner_cyc;
  logic   owner_stb;
  logic   timeout_hit;

  assign owner_cyc = last_q ? m1Cyc_i : m0Cyc_i;
  assign owner_stb = last_q ? m1Stb_i : m0Stb_i;

`ifdef AS_GPIO_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(timeout_cycles + 1);

  logic [CW-1:0] to_cnt_q;
  logic          in_gnt;

  assign in_gnt = (state_q == GNT0) || (state_q == GNT1);

  // The counter holds the number of stalled strobe cycles already seen.
  // The cycle that would make the count reach timeout_cycles is the abort cycle.
  assign timeout_hit = in_gnt && owner_cyc && owner_stb && !sAck_i &&
                       (to_cnt_q == CW'(timeout_cycles - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else if (!in_gnt || (state_d != state_q) || sAck_i) begin
      to_cnt_q <= '0;
    end else if (owner_stb) begin
      to_cnt_q <= to_cnt_q + CW'(1);
    end
  end

  assign m0Err_o = timeout_hit && !last_q;
  assign m1Err_o = timeout_hit &&  last_q;
`else
  assign timeout_hit = 1'b0;
  assign m0Err_o     = 1'b0;
  assign m1Err_o     = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_d == GNT0) begin
        last_q <= 1'b0;
      end else if (state_d == GNT1) begin
        last_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m0Cyc_i && m1Cyc_i) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0Cyc_i) begin
          state_d = GNT0;
        end else if (m1Cyc_i) begin
          state_d = GNT1;
        end
      end
      // A release goes straight to the waiting master so that no dead cycle appears between owners.
      GNT0: begin
        if (!m0Cyc_i) begin
          state_d = m1Cyc_i ? GNT1 : IDLE;
        end else if (timeout_hit) begin
          state_d = ABORT;
        end
      end
      GNT1: begin
        if (!m1Cyc_i) begin
          state_d = m0Cyc_i ? GNT0 : IDLE;
        end else if (timeout_hit) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        if (!owner_cyc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sAddr_o = '0;
    sDat_o  = '0;
    sWe_o   = 1'b0;
    sSel_o  = '0;
    sStb_o  = 1'b0;
    sCyc_o  = 1'b0;
    m0Dat_o = '0;
    m1Dat_o = '0;
    m0Ack_o = 1'b0;
    m1Ack_o = 1'b0;
    gnt_o   = 2'b00;
    busy_o  = 1'b0;
    unique case (state_q)
      GNT0: begin
        sAddr_o = m0Addr_i;
        sDat_o  = m0Dat_i;
        sWe_o   = m0We_i;
        sSel_o  = m0Sel_i;
        sStb_o  = m0Stb_i;
        sCyc_o  = m0Cyc_i;
        m0Dat_o = sDat_i;
        m0Ack_o = sAck_i;
        gnt_o   = 2'b01;
        busy_o  = 1'b1;
      end
      GNT1: begin
        sAddr_o = m1Addr_i;
        sDat_o  = m1Dat_i;
        sWe_o   = m1We_i;
        sSel_o  = m1Sel_i;
        sStb_o  = m1Stb_i;
        sCyc_o  = m1Cyc_i;
        m1Dat_o = sDat_i;
        m1Ack_o = sAck_i;
        gnt_o   = 2'b10;
        busy_o  = 1'b1;
      end
      ABORT: begin
        busy_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
